clock_timebase: RTL

//  Parametrised timebase. Divides the system clock into single-cycle usec, msec and sec tick strobes.

---
 rtl/timebase_pkg.sv | 22 ++
 rtl/clock_timebase_if.sv | 35 +++
 rtl/clock_timebase_tick_divider.sv | 50 +++++
 rtl/clock_timebase.sv | 121 ++++++++++++
 4 files changed

// File: rtl/timebase_pkg.sv
// ============================================================================
// Module      : timebase_pkg
// Description : Shared defaults and width helper for the clock timebase.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package timebase_pkg;

    localparam int CLK_PER_US_100M = 100;
    localparam int US_PER_MS       = 1000;
    localparam int MS_PER_S        = 1000;
    localparam int SEC_W           = 32;

    // A modulo-N counter needs at least one bit even when N is 2.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/clock_timebase_if.sv
// ============================================================================
// Module      : clock_timebase_if
// Description : Control inputs and tick outputs of the clock timebase.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface clock_timebase_if #(
    parameter int PROG_W = 16
);
    import timebase_pkg::*;

    logic                run;
    logic                clear;
    logic [PROG_W-1:0]   prog_period;
    logic                prog_load;
    logic                tick_usec;
    logic                tick_msec;
    logic                tick_sec;
    logic                tick_prog;
    logic [SEC_W-1:0]    sec_count;

    modport master (
        output run, clear, prog_period, prog_load,
        input  tick_usec, tick_msec, tick_sec, tick_prog, sec_count
    );

    modport slave (
        input  run, clear, prog_period, prog_load,
        output tick_usec, tick_msec, tick_sec, tick_prog, sec_count
    );

endinterface

`default_nettype wire

// File: rtl/clock_timebase_tick_divider.sv
// ============================================================================
// Module      : tick_divider
// Description : Modulo-N event counter with registered terminal-count strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_divider
    import timebase_pkg::*;
#(
    parameter int N = 4
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic en_evt,
    input  wire logic hold,
    input  wire logic clr,
    output logic      wrap,
    output logic      tc
);

    localparam int            W      = cnt_width(N);
    localparam logic [W-1:0]  c_last = W'(N - 1);

    logic [W-1:0] r_cnt;
    logic         r_tc;
    logic         w_step;

    assign w_step = en_evt & ~hold & ~clr;
    // Combinational wrap feeds the next tier so all coincident strobes register together.
    assign wrap   = w_step & (r_cnt == c_last);
    assign tc     = r_tc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_tc  <= 1'b0;
        end else begin
            r_tc <= wrap;
            if (clr) begin
                r_cnt <= '0;
            end else if (w_step) begin
                r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/clock_timebase.sv
// ============================================================================
// Module      : clock_timebase
// Description : Divides clk into usec/msec/sec strobes plus a programmable tick.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_timebase #(
    parameter int CLK_PER_US = timebase_pkg::CLK_PER_US_100M,
    parameter int US_PER_MS  = timebase_pkg::US_PER_MS,
    parameter int MS_PER_S   = timebase_pkg::MS_PER_S,
    parameter int PROG_W     = 16
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    clock_timebase_if.slave   bus
);

    import timebase_pkg::*;

    logic                r_rst_meta;
    logic                r_rst_sync;
    logic                w_rst_n;
    logic                w_hold;
    logic                w_usec_evt;
    logic                w_msec_evt;
    logic                w_sec_evt;
    logic                w_prog_last;
    logic [SEC_W-1:0]    r_sec_count;
    logic [PROG_W-1:0]   r_period_q;
    logic [PROG_W-1:0]   r_cnt_prog;
    logic                r_tick_prog;

    // Assert asynchronously, release on the second clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= r_rst_meta;
        end
    end

    assign w_rst_n = r_rst_sync;
    assign w_hold  = ~bus.run;

    tick_divider #(.N(CLK_PER_US)) u_usec (
        .clk    (clk),
        .rst_n  (w_rst_n),
        .en_evt (1'b1),
        .hold   (w_hold),
        .clr    (bus.clear),
        .wrap   (w_usec_evt),
        .tc     (bus.tick_usec)
    );

    tick_divider #(.N(US_PER_MS)) u_msec (
        .clk    (clk),
        .rst_n  (w_rst_n),
        .en_evt (w_usec_evt),
        .hold   (w_hold),
        .clr    (bus.clear),
        .wrap   (w_msec_evt),
        .tc     (bus.tick_msec)
    );

    tick_divider #(.N(MS_PER_S)) u_sec (
        .clk    (clk),
        .rst_n  (w_rst_n),
        .en_evt (w_msec_evt),
        .hold   (w_hold),
        .clr    (bus.clear),
        .wrap   (w_sec_evt),
        .tc     (bus.tick_sec)
    );

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sec_count <= '0;
        end else if (bus.clear) begin
            r_sec_count <= '0;
        end else if (w_sec_evt) begin
            r_sec_count <= r_sec_count + SEC_W'(1);
        end
    end

    assign bus.sec_count = r_sec_count;

    // Runtime modulus, so the programmable tier cannot reuse tick_divider.
    assign w_prog_last = (r_cnt_prog == (r_period_q - PROG_W'(1)));

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_period_q  <= '0;
            r_cnt_prog  <= '0;
            r_tick_prog <= 1'b0;
        end else begin
            r_tick_prog <= 1'b0;
            if (bus.prog_load) begin
                r_period_q <= bus.prog_period;
            end
            // A usec event landing with prog_load is dropped: the count restarts clean.
            if (bus.clear || bus.prog_load || (r_period_q == '0)) begin
                r_cnt_prog <= '0;
            end else if (w_usec_evt) begin
                if (w_prog_last) begin
                    r_cnt_prog  <= '0;
                    r_tick_prog <= 1'b1;
                end else begin
                    r_cnt_prog <= r_cnt_prog + PROG_W'(1);
                end
            end
        end
    end

    assign bus.tick_prog = r_tick_prog;

endmodule

`default_nettype wire
